rx_payload_writer: RTL and testbench

Receive-path stage directly downstream of the RDMA RX header parser. It latches the parsed header (remote address, byte length, opcode) and converts the following payload AXI-Stream into AXI4 memory-mapped write bursts to the target buffer. It splits each transfer at MAX_BURST_LEN and at 4 KB boundaries, masks the final partial word, and handles short and long payloads. It reports completion and errors to the RX control logic.

---
 rtl/rdma_rx_pkg.sv | 30 +++
 rtl/rx_burst_calc.sv | 48 ++++
 rtl/rx_payload_writer.sv | 219 +++++++++++++++++++++
 tb/tb_rx_payload_writer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_rx_pkg.sv
// Shared definitions for the RDMA receive path: writer FSM state encoding,
// AXI4 protocol constants, 4 KB page size and the final-beat strobe mask.
package rdma_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    localparam int unsigned BOUNDARY_4K = 4096;

    // Valid-byte mask for the last beat of a transfer; 0 means a full word.
    function automatic logic [3:0] last_bytes_mask(input logic [1:0] last_bytes);
        case (last_bytes)
            2'd1:    return 4'b0001;
            2'd2:    return 4'b0011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/rx_burst_calc.sv
// Registered burst length calculator.
// Ports: clk/reset (sync, active-high); load captures a new result;
// page_offset is the word-aligned byte offset within the 4 KB page;
// beats is the number of beats still to write. burst_len is the number of
// beats in the next burst, awlen the matching AXI encoding (burst_len - 1).
module rx_burst_calc
    import rdma_rx_pkg::*;
#(
    parameter int unsigned BEATS_WIDTH   = 32,
    parameter int unsigned MAX_BURST_LEN = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [11:0]            page_offset,
    input  logic [BEATS_WIDTH-1:0] beats,
    output logic [8:0]             burst_len,
    output logic [7:0]             awlen
);

    localparam int unsigned LEN_W = 9;

    logic [31:0] page_beats;
    logic [31:0] limit;

    // Smallest of: beats left, burst cap, beats left before the 4 KB page ends.
    always_comb begin
        page_beats = (32'(BOUNDARY_4K) - 32'(page_offset)) >> 2;
        limit      = 32'(MAX_BURST_LEN);
        if (page_beats < limit) begin
            limit = page_beats;
        end
        if (32'(beats) < limit) begin
            limit = 32'(beats);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_len <= '0;
            awlen     <= '0;
        end else if (load) begin
            burst_len <= LEN_W'(limit);
            awlen     <= 8'(limit - 32'd1);
        end
    end

endmodule

// File: rtl/rx_payload_writer.sv
// RDMA RX payload writer: latches a parsed header and turns the payload
// AXI-Stream into AXI4 INCR write bursts, split at MAX_BURST_LEN and 4 KB
// pages, with final-word byte masking and short/long payload handling.
// Ports: aclk/areset (sync, active-high); hdr_* header input;
// s_axis_* payload stream; m_axi_aw*/w*/b* AXI4 write master;
// wr_done/wr_error/wr_opcode completion report; hdr_overrun dropped-header
// pulse; busy high whenever a transfer is in progress.
module rx_payload_writer
    import rdma_rx_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_AXIS_TKEEP_WIDTH = 4,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST_LEN      = 16,
    parameter int unsigned RDMA_ADDR_WIDTH    = 64,
    parameter int unsigned RDMA_LENGTH_WIDTH  = 32
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic                            hdr_valid,
    input  logic [RDMA_ADDR_WIDTH-1:0]      hdr_remote_addr,
    input  logic [RDMA_LENGTH_WIDTH-1:0]    hdr_length,
    input  logic [7:0]                      hdr_opcode,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                      m_axi_awlen,
    output logic [2:0]                      m_axi_awsize,
    output logic [1:0]                      m_axi_awburst,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wlast,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic                            wr_done,
    output logic                            wr_error,
    output logic [7:0]                      wr_opcode,
    output logic                            hdr_overrun,
    output logic                            busy
);

    localparam int unsigned STRB_W    = C_M_AXI_DATA_WIDTH / 8;
    localparam int unsigned BEATS_W   = RDMA_LENGTH_WIDTH;
    localparam int unsigned LEN_EXT_W = RDMA_LENGTH_WIDTH + 1;
    localparam int unsigned LEN_W     = 9;

    wr_state_e                   state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr;
    logic [BEATS_W-1:0]          beats_rem;
    logic [LEN_W-1:0]            burst_rem;
    logic [1:0]                  last_bytes;
    logic [7:0]                  opcode;
    logic                        err;
    logic                        short_pkt;
    logic                        saw_tlast;

    logic [BEATS_W-1:0]          hdr_beats;
    logic [11:0]                 calc_offset;
    logic [BEATS_W-1:0]          calc_beats;
    logic                        calc_load;
    logic [LEN_W-1:0]            burst_len;

    logic                        in_data;
    logic                        final_beat;
    logic                        w_hs;
    logic [STRB_W-1:0]           final_mask;
    logic                        unused_addr_bits;

    assign unused_addr_bits = ^hdr_remote_addr[RDMA_ADDR_WIDTH-1:C_M_AXI_ADDR_WIDTH];

    // ceil(length / 4) without overflowing the length width.
    assign hdr_beats = BEATS_W'((LEN_EXT_W'(hdr_length) + LEN_EXT_W'(3)) >> 2);

    // First burst is sized straight from the header so AW issues the next
    // cycle; later bursts are sized on the first ADDR cycle from the
    // advanced address, and awvalid follows one cycle after.
    assign calc_offset = (state == ST_IDLE) ? {hdr_remote_addr[11:2], 2'b00} : addr[11:0];
    assign calc_beats  = (state == ST_IDLE) ? hdr_beats : beats_rem;
    assign calc_load   = ((state == ST_IDLE) && hdr_valid && (hdr_length != '0))
                       || ((state == ST_ADDR) && !m_axi_awvalid);

    rx_burst_calc #(
        .BEATS_WIDTH   (BEATS_W),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_burst_calc (
        .clk         (aclk),
        .reset       (areset),
        .load        (calc_load),
        .page_offset (calc_offset),
        .beats       (calc_beats),
        .burst_len   (burst_len),
        .awlen       (m_axi_awlen)
    );

    assign m_axi_awaddr  = addr;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;

    // W channel is a pass-through of the stream; after a short payload the
    // rest of the burst is padded with empty-strobe beats.
    assign in_data     = (state == ST_DATA);
    assign final_beat  = (beats_rem == BEATS_W'(1));
    assign final_mask  = final_beat ? STRB_W'(last_bytes_mask(last_bytes)) : '1;
    assign m_axi_wvalid = in_data && (short_pkt || s_axis_tvalid);
    assign m_axi_wdata  = (in_data && !short_pkt) ? C_M_AXI_DATA_WIDTH'(s_axis_tdata) : '0;
    assign m_axi_wstrb  = (in_data && !short_pkt) ? (STRB_W'(s_axis_tkeep) & final_mask) : '0;
    assign m_axi_wlast  = in_data && (burst_rem == LEN_W'(1));
    assign s_axis_tready = (in_data && !short_pkt && m_axi_wready) || (state == ST_DRAIN);
    assign w_hs          = m_axi_wvalid && m_axi_wready;

    assign m_axi_bready = (state == ST_RESP);
    assign busy         = (state != ST_IDLE);
    assign wr_done      = (state == ST_DONE);
    assign wr_error     = (state == ST_DONE) && err;
    assign wr_opcode    = opcode;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            beats_rem     <= '0;
            burst_rem     <= '0;
            last_bytes    <= '0;
            opcode        <= '0;
            err           <= 1'b0;
            short_pkt     <= 1'b0;
            saw_tlast     <= 1'b0;
            m_axi_awvalid <= 1'b0;
            hdr_overrun   <= 1'b0;
        end else begin
            hdr_overrun <= hdr_valid && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (hdr_valid) begin
                        addr       <= {hdr_remote_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
                        err        <= (hdr_remote_addr[1:0] != 2'b00);
                        beats_rem  <= hdr_beats;
                        last_bytes <= hdr_length[1:0];
                        opcode     <= hdr_opcode;
                        short_pkt  <= 1'b0;
                        saw_tlast  <= 1'b0;
                        if (hdr_length == '0) begin
                            state <= ST_DRAIN;
                        end else begin
                            state         <= ST_ADDR;
                            m_axi_awvalid <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (!m_axi_awvalid) begin
                        m_axi_awvalid <= 1'b1;
                    end else if (m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        burst_rem     <= burst_len;
                        state         <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        burst_rem <= burst_rem - LEN_W'(1);
                        if (!short_pkt) begin
                            beats_rem <= beats_rem - BEATS_W'(1);
                            if (s_axis_tlast) begin
                                saw_tlast <= 1'b1;
                                // tlast before the header's last beat: short payload.
                                if (!final_beat) begin
                                    short_pkt <= 1'b1;
                                    err       <= 1'b1;
                                end
                            end
                        end
                        if (burst_rem == LEN_W'(1)) begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        if ((beats_rem != '0) && !short_pkt) begin
                            addr  <= addr + C_M_AXI_ADDR_WIDTH'({burst_len, 2'b00});
                            state <= ST_ADDR;
                        end else if (!saw_tlast) begin
                            // Header length reached but the stream continues.
                            err   <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_payload_writer.sv
// Directed bench for rx_payload_writer: drives headers and payload streams,
// acts as an always-ready AXI slave, records AW/W traffic and completion,
// and compares against hand-computed expectations.
module tb_rx_payload_writer;

    logic        aclk = 1'b0;
    logic        areset;
    logic        hdr_valid;
    logic [63:0] hdr_remote_addr;
    logic [31:0] hdr_length;
    logic [7:0]  hdr_opcode;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic        wr_done;
    logic        wr_error;
    logic [7:0]  wr_opcode;
    logic        hdr_overrun;
    logic        busy;

    always #5 aclk = ~aclk;

    rx_payload_writer dut (
        .aclk            (aclk),
        .areset          (areset),
        .hdr_valid       (hdr_valid),
        .hdr_remote_addr (hdr_remote_addr),
        .hdr_length      (hdr_length),
        .hdr_opcode      (hdr_opcode),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awlen     (m_axi_awlen),
        .m_axi_awsize    (m_axi_awsize),
        .m_axi_awburst   (m_axi_awburst),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_bresp     (m_axi_bresp),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .wr_done         (wr_done),
        .wr_error        (wr_error),
        .wr_opcode       (wr_opcode),
        .hdr_overrun     (hdr_overrun),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] pl_data [$];
    logic        pl_last [$];
    logic [31:0] aw_addr_q [$];
    logic [7:0]  aw_len_q [$];
    logic [3:0]  w_strb_q [$];
    logic        w_last_q [$];
    logic [31:0] w_data_q [$];
    logic [1:0]  resp_tab [4];
    int          sidx;
    int          ovr_cnt;
    bit          done_seen;
    logic        done_err;
    logic [7:0]  done_op;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic load_payload(input int n, input int last_at);
        pl_data.delete();
        pl_last.delete();
        for (int i = 0; i < n; i++) begin
            pl_data.push_back(32'hA500_0000 + 32'(i));
            pl_last.push_back(i == last_at - 1);
        end
    endtask

    function automatic int wlast_count();
        int c = 0;
        foreach (w_last_q[i]) if (w_last_q[i]) c++;
        return c;
    endfunction

    function automatic logic [3:0] strb_and();
        logic [3:0] r = 4'hF;
        foreach (w_strb_q[i]) r &= w_strb_q[i];
        return r;
    endfunction

    // Header pulse, then cycle-by-cycle stream source and AXI slave until
    // wr_done or the cycle budget. inj_cyc injects a stray header.
    task automatic run_xfer(input string name, input logic [63:0] a, input logic [31:0] len,
                            input logic [7:0] op, input int budget, input int inj_cyc,
                            input bit expect_done);
        bit b_pend = 0;
        int b_idx  = 0;
        aw_addr_q.delete(); aw_len_q.delete();
        w_strb_q.delete(); w_last_q.delete(); w_data_q.delete();
        sidx = 0; ovr_cnt = 0; done_seen = 0; done_err = 0; done_op = 0;
        hdr_valid = 1; hdr_remote_addr = a; hdr_length = len; hdr_opcode = op;
        @(posedge aclk); #1;
        hdr_valid = 0; hdr_remote_addr = 64'h0000_0000_0BAD_0100; hdr_length = 32'd4; hdr_opcode = 8'hEE;
        check({name, ".busy"}, 64'(busy), 64'd1);
        check({name, ".awvalid_n1"}, 64'(m_axi_awvalid), 64'(len != 0));
        for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
            hdr_valid = (cyc == inj_cyc);
            if (sidx < pl_data.size()) begin
                s_axis_tvalid = 1; s_axis_tdata = pl_data[sidx];
                s_axis_tkeep = 4'hF; s_axis_tlast = pl_last[sidx];
            end else begin
                s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 0;
            end
            m_axi_bvalid = b_pend;
            m_axi_bresp  = (b_pend && b_idx < 4) ? resp_tab[b_idx] : 2'b00;
            #1;
            if (m_axi_awvalid && m_axi_awready) begin
                aw_addr_q.push_back(m_axi_awaddr);
                aw_len_q.push_back(m_axi_awlen);
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 0;
                b_idx++;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_strb_q.push_back(m_axi_wstrb);
                w_last_q.push_back(m_axi_wlast);
                w_data_q.push_back(m_axi_wdata);
                if (m_axi_wlast) b_pend = 1;
            end
            if (s_axis_tvalid && s_axis_tready) sidx++;
            if (hdr_overrun) ovr_cnt++;
            if (wr_done) begin
                done_seen = 1; done_err = wr_error; done_op = wr_opcode;
            end
            @(posedge aclk); #1;
        end
        hdr_valid = 0; s_axis_tvalid = 0; s_axis_tlast = 0; m_axi_bvalid = 0;
        if (expect_done) check({name, ".done"}, 64'(done_seen), 64'd1);
    endtask

    initial begin
        areset = 1; hdr_valid = 0; hdr_remote_addr = '0; hdr_length = '0; hdr_opcode = '0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
        m_axi_awready = 1; m_axi_wready = 1; m_axi_bresp = 2'b00; m_axi_bvalid = 0;
        for (int i = 0; i < 4; i++) resp_tab[i] = 2'b00;
        repeat (2) @(posedge aclk);
        #1 areset = 0;
        #1;
        check("reset.outs", 64'({m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy,
                                 wr_done, wr_error, hdr_overrun, m_axi_awaddr, m_axi_awlen,
                                 m_axi_wstrb, m_axi_wlast, wr_opcode}), 64'd0);
        check("reset.wdata", 64'(m_axi_wdata), 64'd0);

        // Single full burst.
        load_payload(16, 16);
        run_xfer("t1", 64'h1000, 32'd64, 8'h11, 200, -1, 1);
        check("t1.aw_cnt", 64'(aw_addr_q.size()), 64'd1);
        check("t1.awaddr0", 64'(aw_addr_q[0]), 64'h1000);
        check("t1.awlen0", 64'(aw_len_q[0]), 64'd15);
        check("t1.w_cnt", 64'(w_strb_q.size()), 64'd16);
        check("t1.strb_all", 64'(strb_and()), 64'hF);
        check("t1.wlast_cnt", 64'(wlast_count()), 64'd1);
        check("t1.wlast15", 64'(w_last_q[15]), 64'd1);
        check("t1.wdata5", 64'(w_data_q[5]), 64'hA500_0005);
        check("t1.err", 64'(done_err), 64'd0);
        check("t1.opcode", 64'(done_op), 64'h11);
        check("t1.overrun", 64'(ovr_cnt), 64'd0);

        // 4 KB boundary split.
        load_payload(8, 8);
        run_xfer("t2", 64'h0FF8, 32'd32, 8'h22, 200, -1, 1);
        check("t2.aw_cnt", 64'(aw_addr_q.size()), 64'd2);
        check("t2.awaddr0", 64'(aw_addr_q[0]), 64'h0FF8);
        check("t2.awlen0", 64'(aw_len_q[0]), 64'd1);
        check("t2.awaddr1", 64'(aw_addr_q[1]), 64'h1000);
        check("t2.awlen1", 64'(aw_len_q[1]), 64'd5);
        check("t2.w_cnt", 64'(w_strb_q.size()), 64'd8);
        check("t2.wlast_cnt", 64'(wlast_count()), 64'd2);
        check("t2.err", 64'(done_err), 64'd0);

        // Partial final word: 10 bytes.
        load_payload(3, 3);
        run_xfer("t3", 64'h2000, 32'd10, 8'h33, 200, -1, 1);
        check("t3.awlen0", 64'(aw_len_q[0]), 64'd2);
        check("t3.w_cnt", 64'(w_strb_q.size()), 64'd3);
        check("t3.strb1", 64'(w_strb_q[1]), 64'hF);
        check("t3.strb2", 64'(w_strb_q[2]), 64'h3);
        check("t3.err", 64'(done_err), 64'd0);

        // Short payload: padded beats.
        load_payload(2, 2);
        run_xfer("t4", 64'h3000, 32'd16, 8'h44, 200, -1, 1);
        check("t4.awlen0", 64'(aw_len_q[0]), 64'd3);
        check("t4.w_cnt", 64'(w_strb_q.size()), 64'd4);
        check("t4.strb1", 64'(w_strb_q[1]), 64'hF);
        check("t4.strb2", 64'(w_strb_q[2]), 64'h0);
        check("t4.strb3", 64'(w_strb_q[3]), 64'h0);
        check("t4.wlast3", 64'(w_last_q[3]), 64'd1);
        check("t4.consumed", 64'(sidx), 64'd2);
        check("t4.err", 64'(done_err), 64'd1);

        // Long payload: extra beats drained.
        load_payload(5, 5);
        run_xfer("t5", 64'h4000, 32'd8, 8'h55, 200, -1, 1);
        check("t5.awlen0", 64'(aw_len_q[0]), 64'd1);
        check("t5.w_cnt", 64'(w_strb_q.size()), 64'd2);
        check("t5.consumed", 64'(sidx), 64'd5);
        check("t5.err", 64'(done_err), 64'd1);

        // SLVERR on the first of two bursts.
        load_payload(32, 32);
        resp_tab[0] = 2'b10;
        run_xfer("t6", 64'h5000, 32'd128, 8'h66, 300, -1, 1);
        resp_tab[0] = 2'b00;
        check("t6.aw_cnt", 64'(aw_addr_q.size()), 64'd2);
        check("t6.awaddr1", 64'(aw_addr_q[1]), 64'h5040);
        check("t6.awlen1", 64'(aw_len_q[1]), 64'd15);
        check("t6.w_cnt", 64'(w_strb_q.size()), 64'd32);
        check("t6.err", 64'(done_err), 64'd1);

        // Stray header during DATA.
        load_payload(4, 4);
        run_xfer("t7", 64'h6000, 32'd16, 8'h77, 200, 2, 1);
        check("t7.overrun", 64'(ovr_cnt), 64'd1);
        check("t7.aw_cnt", 64'(aw_addr_q.size()), 64'd1);
        check("t7.awaddr0", 64'(aw_addr_q[0]), 64'h6000);
        check("t7.w_cnt", 64'(w_strb_q.size()), 64'd4);
        check("t7.err", 64'(done_err), 64'd0);
        check("t7.opcode", 64'(done_op), 64'h77);

        // Zero-length transfer with one tlast beat.
        load_payload(1, 1);
        run_xfer("t8", 64'h6100, 32'd0, 8'h88, 50, -1, 1);
        check("t8.aw_cnt", 64'(aw_addr_q.size()), 64'd0);
        check("t8.consumed", 64'(sidx), 64'd1);
        check("t8.err", 64'(done_err), 64'd0);

        // Unaligned address.
        load_payload(1, 1);
        run_xfer("t9", 64'h9002, 32'd4, 8'h99, 50, -1, 1);
        check("t9.awaddr0", 64'(aw_addr_q[0]), 64'h9000);
        check("t9.awlen0", 64'(aw_len_q[0]), 64'd0);
        check("t9.strb0", 64'(w_strb_q[0]), 64'hF);
        check("t9.err", 64'(done_err), 64'd1);

        // Reset in the middle of DATA, then a fresh transfer.
        load_payload(4, 4);
        run_xfer("abort", 64'h7000, 32'd16, 8'h70, 3, -1, 0);
        s_axis_tvalid = 1; s_axis_tdata = 32'hDEAD_BEEF; s_axis_tkeep = 4'hF;
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        #1;
        check("abort.outs", 64'({m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready, busy,
                                 wr_done, wr_error, hdr_overrun, m_axi_awaddr, m_axi_awlen,
                                 m_axi_wstrb, m_axi_wlast, wr_opcode}), 64'd0);
        check("abort.wdata", 64'(m_axi_wdata), 64'd0);
        s_axis_tvalid = 0; s_axis_tdata = '0; s_axis_tkeep = '0;
        load_payload(1, 1);
        run_xfer("t10", 64'h8000, 32'd4, 8'hAA, 50, -1, 1);
        check("t10.awaddr0", 64'(aw_addr_q[0]), 64'h8000);
        check("t10.awlen0", 64'(aw_len_q[0]), 64'd0);
        check("t10.consumed", 64'(sidx), 64'd1);
        check("t10.err", 64'(done_err), 64'd0);
        check("t10.opcode", 64'(done_op), 64'hAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
